ber_checker: RTL
================

# ber_checker

Bit-error-rate checker for the QPSK link, sitting directly downstream of the receiver decimator/slicer inside `top_level`. It takes the recovered bit stream and the transmitter's PRBS9 reference bit. It searches over a delay line for the reference phase that best matches the received stream, locks to that phase, and then accumulates total-bit and error-bit counts for readout.

## Interface
Parameters:
- `DEPTH`, 511: number of candidate reference delays searched, covering phases 0..DEPTH-1.
- `WINDOW`, 511: number of strobed bits compared per candidate phase.
- `CNT_W`, 64: width of the bit and error counters.

Ports:
- `CLK100MHZ`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_enable`  in  1  symbol strobe. Data inputs are sampled only in cycles where it is high; at most one strobe per cycle; arbitrary gaps allowed.
- `i_bit_rx`  in  1  received decided bit.
- `i_bit_ref`  in  1  transmitted PRBS reference bit.
- `i_run`  in  1  level signal from a switch; high enables search and counting.
- `o_bit_count`  out  CNT_W  bits counted while locked.
- `o_bit_errors`  out  CNT_W  mismatches counted while locked.
- `o_aligned`  out  1  high while in LOCK.
- `o_phase`  out  ceil(log2(DEPTH))  locked reference delay.

## Operation
Delay line:
- DEPTH-bit shift register of `i_bit_ref`, shifted on every strobe in every state.
- Tap k is the reference bit delayed by k strobes. Tap 0 is the bit sampled on the current strobe.

State machine (states IDLE, SEARCH, LOCK):
- **IDLE**
  - `o_aligned`=0; counters and `o_phase` hold their values.
  - `i_run`=1 → SEARCH. On entry: clear both counters, cand_phase=0, win_cnt=0, win_err=0, min_err=all-ones, min_phase=0.
- **SEARCH**
  - Each strobe: win_cnt++; win_err++ if `i_bit_rx` != tap[cand_phase].
  - On the strobe completing WINDOW bits, compute the final win_err including that strobe.
    - If final win_err < min_err (strict, so ties keep the lowest phase): min_err=win_err, min_phase=cand_phase.
    - If cand_phase==DEPTH-1 → LOCK with `o_phase`=min_phase, using the updated value.
    - Otherwise cand_phase++ and clear win_cnt/win_err.
- **LOCK**
  - `o_aligned`=1.
  - Each strobe: `o_bit_count`++; `o_bit_errors`++ if `i_bit_rx` != tap[`o_phase`].
  - Both counters saturate at all-ones.
- `i_run`=0 in any state → IDLE on the next edge. This takes priority over a strobe in the same cycle: that strobe is not counted, but the delay line still shifts.
- Reset (`rst`=0), at any time including mid-search:
  - all outputs 0, state IDLE, delay line all zeros.
  - All internal counters are cleared.

Other rules:
- Full search duration is DEPTH×WINDOW strobes.
- win_err is WINDOW-width safe and cannot overflow, since it is never greater than WINDOW.

## Timing
- All outputs are registered.
- Counter updates are visible the cycle after the sampling strobe.
- `o_aligned` and `o_phase` become valid the cycle after the final SEARCH strobe.
- IDLE→SEARCH takes 1 cycle after `i_run` rises. A strobe in the transition cycle is not counted but does shift the delay line.
- No combinational path from inputs to outputs.

## Configuration
- `BER_CHECKER_EARLY_LOCK_EN`
  - **Defined:** a completed window with win_err==0 ends SEARCH immediately. The block locks to that cand_phase on the same edge, skipping the remaining phases.
  - **Undefined:** all DEPTH phases are always swept, and the block locks to the minimum-error phase with lowest-phase tie-break.

## Test plan
Bench settings, unless stated otherwise:
- DEPTH=16, WINDOW=32; reference is PRBS9 with seed 9'b010101011.
- `i_enable` strobes every 4th cycle.
- Macro undefined.

Scenarios:
1. Assert `rst`=0 mid-stream in any state → all outputs 0 within the same cycle (asynchronous). After release with `i_run`=0, outputs stay 0.
2. `i_bit_rx` = reference delayed 5 strobes, no errors; raise `i_run` → `o_aligned`=1 and `o_phase`=5 after 512 strobes. After 1000 further strobes, `o_bit_count`=1000 and `o_bit_errors`=0.
3. Same as 2, then invert every 100th received bit in LOCK → after 1000 strobes, `o_bit_count`=1000 and `o_bit_errors`=10.
4. Reference and received both constant 0 (all phases tie at 0 errors) → `o_phase`=0 and `o_aligned` after 512 strobes. With `BER_CHECKER_EARLY_LOCK_EN` defined → `o_aligned` after 32 strobes, `o_phase`=0.
5. Drop `i_run` in LOCK with count=300 → `o_aligned`=0 next cycle and counters hold 300/0. Raise `i_run` again → counters clear to 0 and a fresh search runs, finishing with `o_phase`=5.
6. Assert `rst` during SEARCH at phase 7 → IDLE with all outputs 0. On restart, the search begins at phase 0 and still locks to 5.

Source files
------------

// File: rtl/ber_checker_if.sv
// ber_checker_if: groups the BER checker's strobe/data inputs and readout outputs.
// Latency: none, this is wiring only.
// Backpressure: none; the symbol strobe is a one-cycle qualifier and cannot be stalled.
// Ports (master = stimulus/receiver side, slave = ber_checker):
//   i_enable, i_bit_rx, i_bit_ref, i_run  : strobe, received bit, PRBS reference bit, run switch
//   o_bit_count, o_bit_errors             : CNT_W-bit counters accumulated while locked
//   o_aligned, o_phase                    : lock flag and locked reference delay
interface ber_checker_if #(
   parameter int CNT_W = 64,
   parameter int PH_W  = 9
);
   logic             i_enable;
   logic             i_bit_rx;
   logic             i_bit_ref;
   logic             i_run;
   logic [CNT_W-1:0] o_bit_count;
   logic [CNT_W-1:0] o_bit_errors;
   logic             o_aligned;
   logic [PH_W-1:0]  o_phase;

   modport master (
      output i_enable, i_bit_rx, i_bit_ref, i_run,
      input  o_bit_count, o_bit_errors, o_aligned, o_phase
   );

   modport slave (
      input  i_enable, i_bit_rx, i_bit_ref, i_run,
      output o_bit_count, o_bit_errors, o_aligned, o_phase
   );
endinterface

// File: rtl/ber_checker.sv
// ber_checker: searches DEPTH reference delays for the best match to the received bit stream, locks, then counts bits/errors.
// Latency: outputs registered; counters update the cycle after the sampling strobe, lock/phase the cycle after the last search strobe.
// Backpressure: none; every strobe is consumed, a low i_run wins over a same-cycle strobe (strobe dropped, delay line still shifts).
// Ports: CLK100MHZ (rising edge), rst (async, active low), bus (ber_checker_if.slave: strobe/data in, counters/lock out).
// Optional feature: define BER_CHECKER_EARLY_LOCK_EN to lock on the first candidate window with zero errors.
module ber_checker #(
   parameter int DEPTH  = 511,
   parameter int WINDOW = 511,
   parameter int CNT_W  = 64
) (
   input  logic         CLK100MHZ,
   input  logic         rst,
   ber_checker_if.slave bus
);
   localparam int PH_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int WIN_W = $clog2(WINDOW + 1);

   typedef enum logic [1:0] {IDLE, SEARCH, LOCK} state_t;

   state_t           state;
   logic [DEPTH-2:0] ref_sr;       // reference delayed by 1..DEPTH-1 strobes
   logic [DEPTH-1:0] taps;         // tap k = reference delayed by k strobes
   logic [PH_W-1:0]  cand_phase;
   logic [PH_W-1:0]  min_phase;
   logic [WIN_W-1:0] win_cnt;
   logic [WIN_W-1:0] win_err;
   logic [WIN_W-1:0] min_err;
   logic [WIN_W-1:0] win_err_fin;
   logic             search_miss;
   logic             lock_miss;
   logic             win_done;
   logic             better;
   logic [PH_W-1:0]  best_phase;

   // Tap 0 is the live input so the bit sampled on this strobe is comparable immediately.
   assign taps        = {ref_sr, bus.i_bit_ref};
   assign search_miss = bus.i_bit_rx ^ taps[cand_phase];
   assign lock_miss   = bus.i_bit_rx ^ taps[bus.o_phase];
   assign win_err_fin = win_err + WIN_W'(search_miss);
   assign win_done    = (win_cnt == WIN_W'(WINDOW - 1));
   // Strict compare: on a tie the earlier (lower) phase is kept.
   assign better      = (win_err_fin < min_err);
   assign best_phase  = better ? cand_phase : min_phase;

   // Delay line shifts on every strobe regardless of state or i_run.
   always_ff @(posedge CLK100MHZ or negedge rst) begin
      if (!rst) begin
         ref_sr <= '0;
      end else if (bus.i_enable) begin
         ref_sr <= taps[DEPTH-2:0];
      end
   end

   always_ff @(posedge CLK100MHZ or negedge rst) begin
      if (!rst) begin
         state            <= IDLE;
         cand_phase       <= '0;
         min_phase        <= '0;
         win_cnt          <= '0;
         win_err          <= '0;
         min_err          <= '0;
         bus.o_bit_count  <= '0;
         bus.o_bit_errors <= '0;
         bus.o_aligned    <= 1'b0;
         bus.o_phase      <= '0;
      end else if (!bus.i_run) begin
         state         <= IDLE;
         bus.o_aligned <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state            <= SEARCH;
               bus.o_bit_count  <= '0;
               bus.o_bit_errors <= '0;
               cand_phase       <= '0;
               win_cnt          <= '0;
               win_err          <= '0;
               min_err          <= '1;
               min_phase        <= '0;
            end
            SEARCH: begin
               if (bus.i_enable) begin
                  if (win_done) begin
                     if (better) begin
                        min_err   <= win_err_fin;
                        min_phase <= cand_phase;
                     end
`ifdef BER_CHECKER_EARLY_LOCK_EN
                     if (win_err_fin == '0) begin
                        state         <= LOCK;
                        bus.o_aligned <= 1'b1;
                        bus.o_phase   <= cand_phase;
                     end else
`endif
                     if (cand_phase == PH_W'(DEPTH - 1)) begin
                        state         <= LOCK;
                        bus.o_aligned <= 1'b1;
                        bus.o_phase   <= best_phase;
                     end else begin
                        cand_phase <= cand_phase + PH_W'(1);
                        win_cnt    <= '0;
                        win_err    <= '0;
                     end
                  end else begin
                     win_cnt <= win_cnt + WIN_W'(1);
                     win_err <= win_err_fin;
                  end
               end
            end
            LOCK: begin
               bus.o_aligned <= 1'b1;
               if (bus.i_enable) begin
                  if (~&bus.o_bit_count) begin
                     bus.o_bit_count <= bus.o_bit_count + CNT_W'(1);
                  end
                  if (lock_miss && ~&bus.o_bit_errors) begin
                     bus.o_bit_errors <= bus.o_bit_errors + CNT_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
